// File: rtl/sisc_pkg.sv
// Shared constants and types for the fetch path: FSM states, default widths,
// and where the opcode lives inside an instruction word.
package sisc_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fq_state_t;

  localparam int SISC_AW = 16;
  localparam int SISC_DW = 32;
  localparam logic [3:0] HALT_OP_DEF = 4'hF;
  localparam int OP_HI = 31;
  localparam int OP_LO = 28;
endpackage

// File: rtl/fetch_queue_if.sv
// Instruction memory read port plus IR-side head/deq/redirect signals of the fetch queue.
interface fetch_queue_if
  import sisc_pkg::*;
#(
  parameter int AW = SISC_AW,
  parameter int DW = SISC_DW,
  parameter int CW = 3
);
  logic          start;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_data;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          deq;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          valid;
  logic [CW-1:0] count;
  logic          halted;

  modport master (
    input  start, im_data, redirect, redirect_addr, deq,
    output im_addr, instr, instr_pc, valid, count, halted
  );

  modport slave (
    output start, im_data, redirect, redirect_addr, deq,
    input  im_addr, instr, instr_pc, valid, count, halted
  );
endinterface

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one synchronous write port, one async read port.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 48,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [DEPTH-1:0][W-1:0] mem;

  // Contents need no reset: readers gate the head with the occupancy count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: walks a private fetch PC through im, buffers words
// with their addresses, flushes on redirect and stops fetching after a halt opcode.
module fetch_queue
  import sisc_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter int         AW      = SISC_AW,
  parameter int         DW      = SISC_DW,
  parameter logic [3:0] HALT_OP = HALT_OP_DEF
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DW + AW;

  fq_state_t     state;
  logic [AW-1:0] fpc;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic [EW-1:0] rd;
  logic          full, valid, push, pop, halt_push;

  assign full  = (cnt == CW'(DEPTH));
  assign valid = (cnt != '0);
  assign pop   = bus.deq && valid;
  // A full queue can still accept a word when the head leaves in the same cycle.
  assign push  = (state == RUN) && !bus.redirect && (!full || bus.deq);
  assign halt_push = push && (bus.im_data[OP_HI:OP_LO] == HALT_OP);

  fq_storage #(.DEPTH(DEPTH), .W(EW)) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata ({bus.im_data, fpc}),
    .raddr (head),
    .rdata (rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fpc   <= '0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
    end else if (bus.redirect) begin
      state <= RUN;
      fpc   <= bus.redirect_addr;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:    if (bus.start) state <= RUN;
        RUN:     if (halt_push) state <= HOLD;
        HOLD:    state <= HOLD;
        default: state <= IDLE;
      endcase
      if (push) begin
        tail <= tail + PW'(1);
        fpc  <= fpc + AW'(1);
      end
      if (pop) head <= head + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign bus.im_addr  = fpc;
  assign bus.valid    = valid;
  assign bus.count    = cnt;
  assign bus.instr    = valid ? rd[EW-1:AW] : '0;
  assign bus.instr_pc = valid ? rd[AW-1:0] : '0;
  assign bus.halted   = (state == HOLD);
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between instruction memory (`im`) and the instruction register (`ir`). It walks a private fetch PC through `im`, buffers up to DEPTH words with their addresses, and presents the oldest word to the IR stage. It decouples fetch from the multi-cycle control FSM. It flushes and refetches on a branch redirect, and stops fetching after it buffers a halt opcode.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, 2..16
- AW, 16, address width (matches `pc`/`im` address)
- DW, 32, instruction width
- HALT_OP, 4'hF, opcode (`instr[31:28]`) that stops fetch

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching at current fetch PC
- im_addr  out  AW  address driven to `im` (current fetch PC)
- im_data  in  DW  `im` read data; combinational for `im_addr` in the same cycle
- redirect  in  1  branch taken: flush queue, refetch from redirect_addr
- redirect_addr  in  AW  branch target
- deq  in  1  consumer (IR load) accepts head word this cycle
- instr  out  DW  head word; 0 when empty
- instr_pc  out  AW  address of head word; 0 when empty
- valid  out  1  queue non-empty
- count  out  $clog2(DEPTH)+1  occupancy
- halted  out  1  FSM in HOLD

## Operation
- FSM states: IDLE, RUN, HOLD.
  - IDLE is entered at reset and never pushes.
  - IDLE→RUN on `start` or `redirect`.
  - RUN→HOLD on the cycle a pushed word has opcode == HALT_OP.
  - HOLD→RUN only on `redirect`.
  - `start` is ignored outside IDLE.
- Push:
  - Condition: in RUN, no redirect this cycle, and (count < DEPTH, or count == DEPTH with deq).
  - Effect: writes {im_data, im_addr} at the tail and advances fetch PC by 1.
  - The fetch PC wraps 16'hFFFF→0.
- Pop: `deq` with valid advances the head. `deq` when empty is ignored: no underflow, count stays 0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect:
  - Clears all entries and sets count to 0.
  - Sets fetch PC to redirect_addr.
  - Enters RUN from any state.
  - Overrides a same-cycle deq and push; the word on `im_data` that cycle is discarded.
- Head/tail pointers are log2(DEPTH) bits and wrap naturally. Full is count == DEPTH.
- Outputs `instr`, `instr_pc`, `valid` and `count` derive combinationally from registered storage, pointers and count. They have no path from `deq`, `redirect` or `im_data`.

## Timing
- Reset values: fetch PC / `im_addr` = 0, count 0, valid 0, `instr` 0, `instr_pc` 0, halted 0, state IDLE.
- Reset has priority over all other inputs, mid-operation included.
- Fetch latency: a word at address A, with im_addr == A in a pushing cycle, appears at the head (if the queue was empty) the following cycle with valid = 1.
- Throughput: one push and one pop per cycle sustained.
- After redirect at cycle N: valid = 0 in N+1; im_addr = redirect_addr in N+1; the first target word is valid in N+2.
- HALT_OP word: it is itself pushed and delivered normally. No further pushes occur; `im_addr` holds at HALT address + 1.
- While full without deq, `im_addr` holds and no push occurs.

## Structure
- Shared package `sisc_pkg`:
  - FSM state enum (IDLE/RUN/HOLD)
  - HALT_OP default value
  - AW/DW width constants
  - opcode field position [31:28]
- Natural sub-module: `fq_storage`, a DEPTH×(DW+AW) register array with write port (we, waddr, wdata) and async read port (raddr). Pointer, count and FSM logic stay in `fetch_queue`.

## Test plan
- Reset, start, no deq, im[i] = 32'h1000_0000+i: after 4 cycles count = 4 and im_addr = 4. The head shows 32'h1000_0000, pc 0. The queue holds while full.
- Full queue with deq held high 8 cycles: instr sequence 0..7 in order, count stays 4, one word per cycle, no drop or duplicate.
- Redirect to 16'h0040 with concurrent deq while count = 3: count = 0 and valid = 0 next cycle. im_addr = 16'h0040. Head = im[16'h40], pc 16'h0040 one cycle later.
- im[5] = 32'hF000_0000: words 0..5 are delivered, halted = 1, im_addr stays 6. A later redirect to 0 resumes fetch from 0.
- deq while empty in IDLE: count stays 0 and no pointer change. start with fetch PC = 16'hFFFF (set via redirect then flush): push at FFFF, then im_addr wraps to 0.
- Reset asserted while full and in RUN: all outputs return to reset values the next cycle and state = IDLE.
